// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the fetch-stage program-counter unit.
//   pc_state_e  : controller states (BOOT / RUN / PEND)
//   pc_src_e    : next-PC source, in priority order, also used by the hazard unit
//   align_mask  : clears the low log2(insn_bytes) bits of a target address
//   pc_src_sel  : priority encoder choosing the next-PC source
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } pc_state_e;

  typedef enum logic [2:0] {
    SRC_TRAP   = 3'd0,  // trap vector
    SRC_REDIR  = 3'd1,  // redirect taken immediately
    SRC_BUFFER = 3'd2,  // release of a buffered redirect
    SRC_LATCH  = 3'd3,  // redirect during stall: buffer it, hold PC
    SRC_HOLD   = 3'd4,  // stall hold
    SRC_SEQ    = 3'd5,  // sequential increment
    SRC_NONE   = 3'd6   // BOOT: all inputs ignored
  } pc_src_e;

  function automatic logic [63:0] align_mask(input int unsigned insn_bytes);
    return ~(64'(insn_bytes) - 64'd1);
  endfunction

  function automatic pc_src_e pc_src_sel(input pc_state_e st, input logic trap,
                                         input logic redir, input logic stall);
    pc_src_e src;
    src = SRC_NONE;
    case (st)
      RUN: begin
        if (trap)                 src = SRC_TRAP;
        else if (redir && !stall) src = SRC_REDIR;
        else if (redir)           src = SRC_LATCH;
        else if (stall)           src = SRC_HOLD;
        else                      src = SRC_SEQ;
      end
      PEND: begin
        if (trap)                 src = SRC_TRAP;
        else if (redir && !stall) src = SRC_REDIR;
        else if (redir)           src = SRC_LATCH;
        else if (!stall)          src = SRC_BUFFER;
        else                      src = SRC_HOLD;
      end
      default:                    src = SRC_NONE;
    endcase
    return src;
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: control and status bundle between the fetch/hazard logic and pc_unit.
//   Inputs to pc_unit : stall, redirect_valid/redirect_pc, trap_valid/trap_vector,
//                       hist_rd_idx
//   Outputs of pc_unit: current_pc, pc_valid, next_seq_pc, misaligned,
//                       hist_rd_pc, hist_count
//   modport slave  : pc_unit side
//   modport master : requester side (hazard unit / testbench)
interface pc_unit_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned HIST_DEPTH = 8
);
  localparam int unsigned IW = $clog2(HIST_DEPTH);

  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            trap_valid;
  logic [XLEN-1:0] trap_vector;
  logic [XLEN-1:0] current_pc;
  logic            pc_valid;
  logic [XLEN-1:0] next_seq_pc;
  logic            misaligned;
  logic [IW-1:0]   hist_rd_idx;
  logic [XLEN-1:0] hist_rd_pc;
  logic [IW:0]     hist_count;

  modport slave (
    input  stall, redirect_valid, redirect_pc, trap_valid, trap_vector, hist_rd_idx,
    output current_pc, pc_valid, next_seq_pc, misaligned, hist_rd_pc, hist_count
  );

  modport master (
    output stall, redirect_valid, redirect_pc, trap_valid, trap_vector, hist_rd_idx,
    input  current_pc, pc_valid, next_seq_pc, misaligned, hist_rd_pc, hist_count
  );
endinterface

// File: rtl/pc_hist_buf.sv
// pc_hist_buf: circular PC-history buffer.
//   clk, rst_n : clock, async active-low reset (clears pointer and count)
//   i_wr_en    : push i_wr_pc as the newest entry
//   i_rd_idx   : read index, 0 = newest
//   o_rd_pc    : entry at i_rd_idx, 0 when i_rd_idx >= o_count (combinational)
//   o_count    : valid entries, saturates at HIST_DEPTH
module pc_hist_buf #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned HIST_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_wr_en,
  input  logic [XLEN-1:0]               i_wr_pc,
  input  logic [$clog2(HIST_DEPTH)-1:0] i_rd_idx,
  output logic [XLEN-1:0]               o_rd_pc,
  output logic [$clog2(HIST_DEPTH):0]   o_count
);
  localparam int unsigned IW = $clog2(HIST_DEPTH);

  logic [XLEN-1:0] r_mem [HIST_DEPTH];
  logic [IW-1:0]   r_wptr;
  logic [IW:0]     r_count;
  logic [IW-1:0]   w_slot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_count <= '0;
    end else if (i_wr_en) begin
      r_wptr <= r_wptr + IW'(1);
      if (r_count != (IW+1)'(HIST_DEPTH)) r_count <= r_count + (IW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[r_wptr] <= i_wr_pc;
  end

  // Newest entry sits just behind the write pointer; wrap is free for power-of-two depth.
  assign w_slot  = r_wptr - IW'(1) - i_rd_idx;
  assign o_rd_pc = ({1'b0, i_rd_idx} < r_count) ? r_mem[w_slot] : '0;
  assign o_count = r_count;
endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with trap/redirect/buffered-redirect/stall/
//   sequential next-PC selection. Redirects arriving under stall are buffered (PEND).
//   clk, rst_n : clock, async active-low reset
//   bus        : pc_unit_if.slave (control inputs, PC/status outputs, history read)
// Optional feature macro: PC_HIST_EN enables the PC-history buffer (pc_hist_buf);
//   without it hist_rd_pc and hist_count read 0.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     INSN_BYTES   = 4,
  parameter int unsigned     HIST_DEPTH   = 8
) (
  input logic     clk,
  input logic     rst_n,
  pc_unit_if.slave bus
);
  localparam logic [XLEN-1:0] LP_MASK = XLEN'(align_mask(INSN_BYTES));
  localparam logic [XLEN-1:0] LP_INC  = XLEN'(INSN_BYTES);

  pc_state_e       r_state, w_next_state;
  logic [XLEN-1:0] r_pc, r_pend_pc, w_next_pc, w_seq_pc;
  logic            r_valid, r_mis, r_pend_mis, w_next_mis, w_load, w_pend_we;
  pc_src_e         w_src;

  assign w_seq_pc = r_pc + LP_INC;
  assign w_src    = pc_src_sel(r_state, bus.trap_valid, bus.redirect_valid, bus.stall);

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_mis   = 1'b0;
    w_load       = 1'b0;
    w_pend_we    = 1'b0;
    case (w_src)
      SRC_TRAP: begin
        w_load       = 1'b1;
        w_next_pc    = bus.trap_vector & LP_MASK;
        w_next_mis   = |(bus.trap_vector & ~LP_MASK);
        w_next_state = RUN;
      end
      SRC_REDIR: begin
        w_load       = 1'b1;
        w_next_pc    = bus.redirect_pc & LP_MASK;
        w_next_mis   = |(bus.redirect_pc & ~LP_MASK);
        w_next_state = RUN;
      end
      SRC_BUFFER: begin
        w_load       = 1'b1;
        w_next_pc    = r_pend_pc;
        w_next_mis   = r_pend_mis;
        w_next_state = RUN;
      end
      SRC_LATCH: begin
        w_pend_we    = 1'b1;
        w_next_state = PEND;
      end
      SRC_SEQ: begin
        w_load    = 1'b1;
        w_next_pc = w_seq_pc;
      end
      SRC_HOLD: ;
      default:  w_next_state = RUN;  // BOOT lasts exactly one cycle
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= BOOT;
      r_pc       <= RESET_VECTOR;
      r_valid    <= 1'b0;
      r_mis      <= 1'b0;
      r_pend_pc  <= '0;
      r_pend_mis <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_mis   <= w_next_mis;
      if (r_state == BOOT) r_valid <= 1'b1;
      if (w_load) r_pc <= w_next_pc;
      if (w_pend_we) begin
        r_pend_pc  <= bus.redirect_pc & LP_MASK;
        r_pend_mis <= |(bus.redirect_pc & ~LP_MASK);
      end
    end
  end

  assign bus.current_pc  = r_pc;
  assign bus.pc_valid    = r_valid;
  assign bus.next_seq_pc = w_seq_pc;
  assign bus.misaligned  = r_mis;

`ifdef PC_HIST_EN
  pc_hist_buf #(
    .XLEN      (XLEN),
    .HIST_DEPTH(HIST_DEPTH)
  ) u_hist (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr_en (w_load),
    .i_wr_pc (r_pc),
    .i_rd_idx(bus.hist_rd_idx),
    .o_rd_pc (bus.hist_rd_pc),
    .o_count (bus.hist_count)
  );
`else
  assign bus.hist_rd_pc = '0;
  assign bus.hist_count = '0;
`endif
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: self-checking bench for pc_unit (XLEN=32, RESET_VECTOR=0, INSN_BYTES=4,
//   HIST_DEPTH=8). Expected PC/status records are queued as stimulus is applied and
//   compared against the records captured after each clock edge.
module tb_pc_unit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_unit_if #(.XLEN(32), .HIST_DEPTH(8)) bus ();

  pc_unit #(
    .XLEN        (32),
    .RESET_VECTOR(32'h0),
    .INSN_BYTES  (4),
    .HIST_DEPTH  (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic        mis;
    logic [31:0] nseq;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic set_in(input logic s, input logic rv, input logic [31:0] rpc,
                        input logic tv, input logic [31:0] tvec);
    bus.stall          = s;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.trap_valid     = tv;
    bus.trap_vector    = tvec;
  endtask

  // Queue the expectation for the coming edge, advance one cycle, capture the outputs.
  task automatic tick(input logic [31:0] e_pc, input logic e_mis);
    rec_t e, o;
    e.pc = e_pc; e.valid = 1'b1; e.mis = e_mis; e.nseq = e_pc + 32'd4;
    exp_q.push_back(e);
    @(posedge clk); #1;
    o.pc = bus.current_pc; o.valid = bus.pc_valid; o.mis = bus.misaligned;
    o.nseq = bus.next_seq_pc;
    obs_q.push_back(o);
  endtask

  task automatic test_reset;
    rec_t e, o;
    int k = 0;
    set_in(0, 0, 0, 0, 0);
    bus.hist_rd_idx = '0;
    rst_n = 1'b0;
    #12;
    n_vec++; if (bus.current_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", bus.current_pc, 32'h0); end
    n_vec++; if (bus.pc_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.pc_valid); end
    n_vec++; if (bus.misaligned !== 1'b0) begin n_err++; $display("FAIL reset_mis: got %b want 0", bus.misaligned); end
    n_vec++; if (bus.hist_count !== 4'd0) begin n_err++; $display("FAIL reset_hcount: got %0d want 0", bus.hist_count); end
    rst_n = 1'b1;
    tick(32'h0, 0);  // BOOT exit: PC still at reset vector, now valid
    tick(32'h4, 0);
    tick(32'h8, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL reset_seq[%0d]: got pc=%h v=%b mis=%b nseq=%h want pc=%h v=%b mis=%b nseq=%h", k, o.pc, o.valid, o.mis, o.nseq, e.pc, e.valid, e.mis, e.nseq); end
      k++;
    end
  endtask

  task automatic test_stall_redirect;
    rec_t e, o;
    int k = 0;
    tick(32'hC, 0);
    tick(32'h10, 0);
    set_in(1, 1, 32'h40, 0, 0); tick(32'h10, 0);
    set_in(1, 0, 0, 0, 0);      tick(32'h10, 0); tick(32'h10, 0);
    set_in(0, 0, 0, 0, 0);      tick(32'h40, 0); tick(32'h44, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL stall_redirect[%0d]: got pc=%h v=%b mis=%b nseq=%h want pc=%h v=%b mis=%b nseq=%h", k, o.pc, o.valid, o.mis, o.nseq, e.pc, e.valid, e.mis, e.nseq); end
      k++;
    end
  endtask

  task automatic test_pend_trap;
    rec_t e, o;
    int k = 0;
    set_in(1, 1, 32'h40, 0, 0);    tick(32'h44, 0);
    set_in(1, 1, 32'h80, 0, 0);    tick(32'h44, 0);
    set_in(0, 0, 0, 1, 32'h100);   tick(32'h100, 0);
    set_in(0, 0, 0, 0, 0);         tick(32'h104, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL pend_trap[%0d]: got pc=%h v=%b mis=%b nseq=%h want pc=%h v=%b mis=%b nseq=%h", k, o.pc, o.valid, o.mis, o.nseq, e.pc, e.valid, e.mis, e.nseq); end
      k++;
    end
  endtask

  task automatic test_pend_newest;
    rec_t e, o;
    int k = 0;
    set_in(1, 1, 32'h200, 0, 0); tick(32'h104, 0);
    set_in(1, 1, 32'h300, 0, 0); tick(32'h104, 0);
    set_in(1, 0, 0, 0, 0);       tick(32'h104, 0);
    set_in(0, 0, 0, 0, 0);       tick(32'h300, 0); tick(32'h304, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL pend_newest[%0d]: got pc=%h v=%b mis=%b nseq=%h want pc=%h v=%b mis=%b nseq=%h", k, o.pc, o.valid, o.mis, o.nseq, e.pc, e.valid, e.mis, e.nseq); end
      k++;
    end
  endtask

  task automatic test_trap_stall;
    rec_t e, o;
    int k = 0;
    set_in(1, 0, 0, 1, 32'h400);  tick(32'h400, 0);
    set_in(1, 0, 0, 0, 0);        tick(32'h400, 0);
    set_in(0, 0, 0, 0, 0);        tick(32'h404, 0);
    set_in(0, 1, 32'h600, 0, 0);  tick(32'h600, 0);
    set_in(0, 0, 0, 0, 0);        tick(32'h604, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL trap_stall[%0d]: got pc=%h v=%b mis=%b nseq=%h want pc=%h v=%b mis=%b nseq=%h", k, o.pc, o.valid, o.mis, o.nseq, e.pc, e.valid, e.mis, e.nseq); end
      k++;
    end
  endtask

  task automatic test_misaligned;
    rec_t e, o;
    int k = 0;
    set_in(0, 1, 32'h22, 0, 0);   tick(32'h20, 1);
    set_in(0, 0, 0, 0, 0);        tick(32'h24, 0);
    set_in(0, 0, 0, 1, 32'h103);  tick(32'h100, 1);
    set_in(0, 0, 0, 0, 0);        tick(32'h104, 0);
    set_in(1, 1, 32'h56, 0, 0);   tick(32'h104, 0);
    set_in(0, 0, 0, 0, 0);        tick(32'h54, 1); tick(32'h58, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL misaligned[%0d]: got pc=%h v=%b mis=%b nseq=%h want pc=%h v=%b mis=%b nseq=%h", k, o.pc, o.valid, o.mis, o.nseq, e.pc, e.valid, e.mis, e.nseq); end
      k++;
    end
  endtask

  task automatic test_wrap;
    rec_t e, o;
    int k = 0;
    set_in(0, 1, 32'hFFFF_FFFC, 0, 0); tick(32'hFFFF_FFFC, 0);
    set_in(0, 0, 0, 0, 0);             tick(32'h0, 0); tick(32'h4, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL wrap[%0d]: got pc=%h v=%b mis=%b nseq=%h want pc=%h v=%b mis=%b nseq=%h", k, o.pc, o.valid, o.mis, o.nseq, e.pc, e.valid, e.mis, e.nseq); end
      k++;
    end
  endtask

  task automatic test_reset_mid_pend;
    rec_t e, o;
    int k = 0;
    set_in(1, 1, 32'h500, 0, 0); tick(32'h4, 0);
    rst_n = 1'b0; #2;
    n_vec++; if (bus.current_pc !== 32'h0) begin n_err++; $display("FAIL midreset_pc: got %h want %h", bus.current_pc, 32'h0); end
    n_vec++; if (bus.pc_valid !== 1'b0) begin n_err++; $display("FAIL midreset_valid: got %b want 0", bus.pc_valid); end
    set_in(0, 0, 0, 0, 0); #2;
    rst_n = 1'b1;
    tick(32'h0, 0); tick(32'h4, 0); tick(32'h8, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL midreset_seq[%0d]: got pc=%h v=%b mis=%b nseq=%h want pc=%h v=%b mis=%b nseq=%h", k, o.pc, o.valid, o.mis, o.nseq, e.pc, e.valid, e.mis, e.nseq); end
      k++;
    end
  endtask

  task automatic test_hist;
    rec_t e, o;
    int k = 0;
`ifdef PC_HIST_EN
    rst_n = 1'b0; #2; rst_n = 1'b1;
    tick(32'h0, 0);  // BOOT: no history write
    n_vec++; if (bus.hist_count !== 4'd0) begin n_err++; $display("FAIL hist_boot_count: got %0d want 0", bus.hist_count); end
    for (int i = 1; i <= 10; i++) begin
      tick(32'(4 * i), 0);
      if (i == 3) begin
        n_vec++; if (bus.hist_count !== 4'd3) begin n_err++; $display("FAIL hist_count3: got %0d want 3", bus.hist_count); end
        bus.hist_rd_idx = 3'd3; #1;
        n_vec++; if (bus.hist_rd_pc !== 32'h0) begin n_err++; $display("FAIL hist_oob: got %h want 0", bus.hist_rd_pc); end
        bus.hist_rd_idx = 3'd0; #1;
        n_vec++; if (bus.hist_rd_pc !== 32'h8) begin n_err++; $display("FAIL hist_idx0_early: got %h want %h", bus.hist_rd_pc, 32'h8); end
      end
    end
    n_vec++; if (bus.hist_count !== 4'd8) begin n_err++; $display("FAIL hist_count_sat: got %0d want 8", bus.hist_count); end
    bus.hist_rd_idx = 3'd0; #1;
    n_vec++; if (bus.hist_rd_pc !== 32'h24) begin n_err++; $display("FAIL hist_idx0: got %h want %h", bus.hist_rd_pc, 32'h24); end
    bus.hist_rd_idx = 3'd7; #1;
    n_vec++; if (bus.hist_rd_pc !== 32'h08) begin n_err++; $display("FAIL hist_idx7: got %h want %h", bus.hist_rd_pc, 32'h08); end
    rst_n = 1'b0; #2; rst_n = 1'b1; #1;
    n_vec++; if (bus.hist_count !== 4'd0) begin n_err++; $display("FAIL hist_reset_count: got %0d want 0", bus.hist_count); end
`else
    bus.hist_rd_idx = 3'd3; tick(32'hC, 0); #1;
    n_vec++; if (bus.hist_count !== 4'd0) begin n_err++; $display("FAIL hist_off_count: got %0d want 0", bus.hist_count); end
    n_vec++; if (bus.hist_rd_pc !== 32'h0) begin n_err++; $display("FAIL hist_off_pc: got %h want 0", bus.hist_rd_pc); end
`endif
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL hist_seq[%0d]: got pc=%h v=%b mis=%b nseq=%h want pc=%h v=%b mis=%b nseq=%h", k, o.pc, o.valid, o.mis, o.nseq, e.pc, e.valid, e.mis, e.nseq); end
      k++;
    end
  endtask

  initial begin
    test_reset;
    test_stall_redirect;
    test_pend_trap;
    test_pend_newest;
    test_trap_stall;
    test_misaligned;
    test_wrap;
    test_reset_mid_pend;
    test_hist;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1);
  end
endmodule
